// File: rtl/present_pkg.sv
// Shared widths, FSM encoding and the inverse bit-permutation index for the PRESENT-80 decryptor.
package present_pkg;
   localparam int ROUNDS  = 31;
   localparam int BLOCK_W = 64;
   localparam int KEY_W   = 80;
   localparam int NIB_W   = 4;
   localparam int CNT_W   = 5;

   typedef enum logic [2:0] {IDLE, EXPAND, DECRYPT, FINAL, DONE} fsm_t;

   // Destination of bit j under the inverse pLayer; the top bit never moves.
   function automatic int inv_p_idx(input int j);
      return (j == BLOCK_W - 1) ? j : (4 * j) % (BLOCK_W - 1);
   endfunction
endpackage

// File: rtl/inv_sbox.sv
// PRESENT inverse 4-bit S-box, used by the decrypt datapath and the inverse key update.
module inv_sbox
   import present_pkg::*;
(
   input  logic [NIB_W-1:0] din,
   output logic [NIB_W-1:0] dout
);
   always_comb begin
      case (din)
         4'h0: dout = 4'h5;
         4'h1: dout = 4'hE;
         4'h2: dout = 4'hF;
         4'h3: dout = 4'h8;
         4'h4: dout = 4'hC;
         4'h5: dout = 4'h1;
         4'h6: dout = 4'h2;
         4'h7: dout = 4'hD;
         4'h8: dout = 4'hB;
         4'h9: dout = 4'h4;
         4'hA: dout = 4'h6;
         4'hB: dout = 4'h3;
         4'hC: dout = 4'h0;
         4'hD: dout = 4'h7;
         4'hE: dout = 4'h9;
         default: dout = 4'hA;
      endcase
   end
endmodule

// File: rtl/sbox.sv
// PRESENT forward 4-bit S-box, used by the forward key schedule.
module sbox
   import present_pkg::*;
(
   input  logic [NIB_W-1:0] din,
   output logic [NIB_W-1:0] dout
);
   always_comb begin
      case (din)
         4'h0: dout = 4'hC;
         4'h1: dout = 4'h5;
         4'h2: dout = 4'h6;
         4'h3: dout = 4'hB;
         4'h4: dout = 4'h9;
         4'h5: dout = 4'h0;
         4'h6: dout = 4'hA;
         4'h7: dout = 4'hD;
         4'h8: dout = 4'h3;
         4'h9: dout = 4'hE;
         4'hA: dout = 4'hF;
         4'hB: dout = 4'h8;
         4'hC: dout = 4'h4;
         4'hD: dout = 4'h7;
         4'hE: dout = 4'h1;
         default: dout = 4'h2;
      endcase
   end
endmodule

// File: rtl/present_dec.sv
// Iterative PRESENT-80 decryptor: expands the key to K32, then unwinds 31 rounds one per cycle.
// Optional macro PRESENT_DEC_KEYCACHE_EN caches the last master key and its K32 to skip expansion.
module present_dec
   import present_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [BLOCK_W-1:0]  in_data,
   input  logic [KEY_W-1:0]    in_key,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [BLOCK_W-1:0]  out_data
);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(ROUNDS);
   localparam logic [CNT_W-1:0] CNT_FIRST = CNT_W'(1);

   fsm_t               fsm;
   logic [BLOCK_W-1:0] state;
   logic [KEY_W-1:0]   key;
   logic [CNT_W-1:0]   cnt;

   logic [KEY_W-1:0]   key_rot, key_fwd, key_x, key_tmp, key_inv;
   logic [NIB_W-1:0]   fwd_nib, inv_nib;
   logic [BLOCK_W-1:0] ark, perm, dec_next;
   logic               cache_hit;

   assign in_ready = (fsm == IDLE);

   // Forward schedule step: rotl61, S-box on top nibble, counter into bits [19:15].
   assign key_rot = {key[18:0], key[79:19]};
   sbox u_sbox (.din(key_rot[79:76]), .dout(fwd_nib));
   assign key_fwd = {fwd_nib, key_rot[75:20], key_rot[19:15] ^ cnt, key_rot[14:0]};

   // Inverse schedule step: undo the counter, undo the S-box, then rotr61.
   assign key_x = {key[79:20], key[19:15] ^ cnt, key[14:0]};
   inv_sbox u_inv_key (.din(key_x[79:76]), .dout(inv_nib));
   assign key_tmp = {inv_nib, key_x[75:0]};
   assign key_inv = {key_tmp[60:0], key_tmp[79:61]};

   assign ark = state ^ key[79:16];

   for (genvar j = 0; j < BLOCK_W; j++) begin : g_invp
      assign perm[inv_p_idx(j)] = ark[j];
   end

   for (genvar n = 0; n < BLOCK_W / NIB_W; n++) begin : g_invs
      inv_sbox u_inv (.din(perm[NIB_W*n +: NIB_W]), .dout(dec_next[NIB_W*n +: NIB_W]));
   end

`ifdef PRESENT_DEC_KEYCACHE_EN
   logic [KEY_W-1:0] cache_key, cache_k32;
   logic             cache_vld;
   assign cache_hit = cache_vld && (in_key == cache_key);
`else
   assign cache_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm       <= IDLE;
         state     <= '0;
         key       <= '0;
         cnt       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
`ifdef PRESENT_DEC_KEYCACHE_EN
         cache_key <= '0;
         cache_k32 <= '0;
         cache_vld <= 1'b0;
`endif
      end else begin
         case (fsm)
            IDLE: begin
               if (in_valid) begin
                  state <= in_data;
                  if (cache_hit) begin
                     key <= cache_k32_value();
                     cnt <= CNT_LAST;
                     fsm <= DECRYPT;
                  end else begin
                     key <= in_key;
                     cnt <= CNT_FIRST;
                     fsm <= EXPAND;
`ifdef PRESENT_DEC_KEYCACHE_EN
                     cache_key <= in_key;
                     cache_vld <= 1'b0;
`endif
                  end
               end
            end
            EXPAND: begin
               key <= key_fwd;
               if (cnt == CNT_LAST) begin
                  fsm <= DECRYPT;
`ifdef PRESENT_DEC_KEYCACHE_EN
                  cache_k32 <= key_fwd;
                  cache_vld <= 1'b1;
`endif
               end else begin
                  cnt <= cnt + CNT_FIRST;
               end
            end
            DECRYPT: begin
               state <= dec_next;
               key   <= key_inv;
               cnt   <= cnt - CNT_FIRST;
               if (cnt == CNT_FIRST) fsm <= FINAL;
            end
            FINAL: begin
               out_data  <= ark;
               out_valid <= 1'b1;
               fsm       <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  fsm       <= IDLE;
               end
            end
            default: fsm <= IDLE;
         endcase
      end
   end

   // Cached K32 when the cache exists; otherwise the hit path is unreachable.
   function automatic logic [KEY_W-1:0] cache_k32_value();
`ifdef PRESENT_DEC_KEYCACHE_EN
      return cache_k32;
`else
      return key;
`endif
   endfunction
endmodule

// File: tb/tb_present_dec.sv
// Directed self-checking bench for present_dec using published PRESENT-80 vectors.
module tb_present_dec;
   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [63:0]  in_data;
   logic [79:0]  in_key;
   logic         out_valid;
   logic         out_ready;
   logic [63:0]  out_data;

   int checks = 0;
   int errors = 0;

   localparam logic [79:0] K0 = 80'h0;
   localparam logic [79:0] K1 = {80{1'b1}};
   localparam logic [63:0] Z64 = 64'h0;
   localparam logic [63:0] F64 = 64'hFFFF_FFFF_FFFF_FFFF;

   present_dec dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_key(in_key),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run_req(input string tag, input logic [63:0] ct, input logic [79:0] k,
                          input logic [63:0] pt, input int lat_exp, input bit hold);
      int lat;
      @(negedge clk);
      in_valid = 1'b1; in_data = ct; in_key = k;
      @(posedge clk); #1;
      chk({tag, "_busy"}, 80'(in_ready), 80'(0));
      // Junk request held during the busy period must be ignored.
      in_data = ~ct; in_key = ~k;
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!out_valid && lat < 200);
      chk({tag, "_lat"}, 80'(lat), 80'(lat_exp));
      chk({tag, "_data"}, 80'(out_data), 80'(pt));
      if (hold) begin
         for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_vld"}, 80'(out_valid), 80'(1));
            chk({tag, "_hold_data"}, 80'(out_data), 80'(pt));
            chk({tag, "_hold_rdy"}, 80'(in_ready), 80'(0));
         end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, "_hs_vld"}, 80'(out_valid), 80'(0));
      chk({tag, "_hs_rdy"}, 80'(in_ready), 80'(1));
      in_valid = 1'b0;
      chk({tag, "_keep"}, 80'(out_data), 80'(pt));
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int seen;
      rst_n = 1'b1; in_valid = 1'b0; in_data = '0; in_key = '0; out_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_vld", 80'(out_valid), 80'(0));
      chk("rst_data", 80'(out_data), 80'(0));
      chk("rst_rdy", 80'(in_ready), 80'(1));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      run_req("v1", 64'h5579C1387B228445, K0, Z64, 63, 1'b0);
      run_req("v2", 64'hE72C46C0F5945049, K1, Z64, 63, 1'b0);
      run_req("v3", 64'hA112FFC72F68417B, K0, F64, 63, 1'b0);
      run_req("v4", 64'h3333DCD3213210D2, K1, F64, 63, 1'b1);

      // Reset 40 edges into a request.
      @(negedge clk);
      in_valid = 1'b1; in_data = 64'h5579C1387B228445; in_key = K0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (40) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_vld", 80'(out_valid), 80'(0));
      chk("mid_rst_rdy", 80'(in_ready), 80'(1));
      chk("mid_rst_data", 80'(out_data), 80'(0));
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 70; i++) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) seen++;
      end
      chk("post_rst_quiet", 80'(seen), 80'(0));
      run_req("v5", 64'h5579C1387B228445, K0, Z64, 63, 1'b0);

      pulse_reset();
`ifdef PRESENT_DEC_KEYCACHE_EN
      run_req("c1", 64'h5579C1387B228445, K0, Z64, 63, 1'b0);
      run_req("c2", 64'hA112FFC72F68417B, K0, F64, 32, 1'b0);
      run_req("c3", 64'hE72C46C0F5945049, K1, Z64, 63, 1'b0);
`else
      run_req("c1", 64'h5579C1387B228445, K0, Z64, 63, 1'b0);
      run_req("c2", 64'hA112FFC72F68417B, K0, F64, 63, 1'b0);
      run_req("c3", 64'hE72C46C0F5945049, K1, Z64, 63, 1'b0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/present_dec.md
PRESENT_DEC -- requirements
Module: present_dec

Interface
REQ-001 clk  input  1  single clock; all state updates on its rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 in_valid  input  1  ciphertext/key request valid.
REQ-004 in_ready  output  1  block idle and able to accept a request; combinational decode of the FSM state.
REQ-005 in_data  input  64  ciphertext block.
REQ-006 in_key  input  80  PRESENT-80 master key.
REQ-007 out_valid  output  1  plaintext valid.
REQ-008 out_ready  input  1  consumer accepts the plaintext.
REQ-009 out_data  output  64  recovered plaintext.

Function
REQ-010 The block SHALL implement PRESENT-80 decryption: the exact inverse of 31 rounds of addRoundKey, sBoxLayer and pLayer, followed by the final addRoundKey with K32.
REQ-011 The inverse S-box SHALL map nibble values 0..F to 5,E,F,8,C,1,2,D,B,4,6,3,0,7,9,A.
REQ-012 The inverse pLayer SHALL move bit j to bit (4*j mod 63) for j=0..62, with bit 63 fixed.
REQ-013 The round key SHALL always be key register bits [79:16].
REQ-014 The FSM SHALL have exactly these states: IDLE, EXPAND, DECRYPT, FINAL, DONE. in_ready SHALL be high only in IDLE.
REQ-015 IDLE transition: on in_valid && in_ready, capture state<=in_data, key<=in_key, cnt<=1, and go to EXPAND.
REQ-016 EXPAND, for cnt=1..31, one step per cycle: key<=rotl61(key), then the top nibble passes through the forward S-box, then bits[19:15] ^= cnt. After the cnt=31 step, load cnt<=31 and go to DECRYPT.
REQ-017 DECRYPT, for cnt=31 down to 1, one step per cycle: state<=invS(invP(state ^ key[79:16])). In the same cycle the key does the inverse update: bits[19:15] ^= cnt, then the top nibble passes through the inverse S-box, then rotr61. After cnt=1, go to FINAL.
REQ-018 FINAL: out_data<=state ^ key[79:16], out_valid<=1, go to DONE.
REQ-019 DONE: hold out_valid and out_data stable until out_ready is high. On that edge, out_valid<=0 and the FSM goes to IDLE. No request is accepted on the same edge.
REQ-020 Latency: out_valid SHALL rise exactly 63 rising edges after the accepting edge (31 EXPAND + 31 DECRYPT + 1 FINAL). Throughput is one block per 64+ cycles.
REQ-021 in_valid, in_data and in_key SHALL be ignored while in_ready is low.
REQ-022 out_data SHALL keep the last plaintext after the handshake, until the next FINAL.

Reset
REQ-023 Asserting rst_n low at any time, including mid-EXPAND or mid-DECRYPT, SHALL immediately force IDLE, out_valid=0, out_data=0, cnt=0, state and key registers to 0, and in_ready=1. Any in-flight block is discarded.
REQ-024 Deasserting rst_n SHALL produce no output activity until a new request is accepted.

Configuration
REQ-025 Macro PRESENT_DEC_KEYCACHE_EN defined: the block SHALL keep a cached master key, its K32, and a cache-valid flag. The flag is cleared by reset and set at the end of EXPAND.
REQ-026 With the macro defined, an accepted request whose in_key equals the cached master key while the flag is set SHALL skip EXPAND. The key register loads the cached K32 and the FSM enters DECRYPT directly, giving a latency of 32 edges.
REQ-027 Macro undefined: no cache storage or comparator SHALL exist, and every request takes 63 edges.

Structure
REQ-028 Package present_pkg SHALL hold ROUNDS=31, the block, key and nibble widths, the FSM state enum, and the inverse-pLayer index function.
REQ-029 One new sub-module inv_sbox (4-bit, combinational) SHALL be instantiated 16x in the datapath and once in the inverse key update. The forward key update SHALL reuse the existing sbox module.

Verification
REQ-030 key=0, ct=5579C1387B228445 -> out_data=0000000000000000, out_valid high exactly 63 edges after accept.
REQ-031 key=FFFFFFFFFFFFFFFFFFFF, ct=E72C46C0F5945049 -> 0000000000000000. Also key=0, ct=A112FFC72F68417B -> FFFFFFFFFFFFFFFF.
REQ-032 key=all-ones, ct=3333DCD3213210D2 -> FFFFFFFFFFFFFFFF, with out_ready held low 10 cycles: out_valid and out_data stable, in_ready low throughout.
REQ-033 rst_n pulsed low at cycle 40 after accept -> out_valid 0, in_ready 1 immediately. A following request (key=0, ct=5579C1387B228445) returns 0 with full latency.
REQ-034 Macro defined: two back-to-back requests with key=0 -> first has latency 63, second has latency 32, both correct. A third request with key=all-ones has latency 63.
